// File: rtl/dino_frame_writer_if.sv
// Register write port from the Dino game engine into the VGA sprite display block.
// No waitrequest: every cycle with chipselect&write is one completed register write.
interface dino_frame_writer_if;
    logic        chipselect;
    logic        write;
    logic [8:0]  address;
    logic [31:0] writedata;

    modport master (output chipselect, write, address, writedata);
    modport slave  (input  chipselect, write, address, writedata);
endinterface

// File: rtl/dino_frame_writer.sv
// Dino Run engine: on each VGA_VS falling edge updates jump/cactus/score, then bursts 5 register writes starting 2 cycles later.
// No backpressure on the write port; ticks arriving while busy are dropped. Define COLLISION_EN to enable collision and GAME_OVER.
module dino_frame_writer #(
    parameter int unsigned DINO_X      = 100,
    parameter int unsigned GROUND_Y    = 100,
    parameter int unsigned JUMP_STEP   = 4,
    parameter int unsigned JUMP_FRAMES = 12,
    parameter int unsigned CAC_START_X = 250,
    parameter int unsigned SCROLL_STEP = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       vga_vs,
    input  logic                       jump_btn,
    input  logic                       restart,
    dino_frame_writer_if.master        bus,
    output logic                       busy,
    output logic                       game_over,
    output logic [3:0]                 score
);

    localparam logic [7:0] DINO_X8   = 8'(DINO_X);
    localparam logic [7:0] GROUND8   = 8'(GROUND_Y);
    localparam logic [7:0] STEP8     = 8'(JUMP_STEP);
    localparam logic [7:0] LAST_CNT  = 8'(JUMP_FRAMES - 1);
    localparam logic [7:0] CAC_START = 8'(CAC_START_X);
    localparam logic [7:0] SCROLL8   = 8'(SCROLL_STEP);

    typedef enum logic [2:0] {
        S_IDLE, S_UPDATE, S_WR0, S_WR1, S_WR2, S_WR3, S_WR4, S_GAME_OVER
    } state_t;

    typedef enum logic [1:0] {
        PH_GROUND, PH_RISE, PH_FALL
    } phase_t;

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  dino_y_q, dino_y_d;
    logic [7:0]  cac_x_q, cac_x_d;
    logic [3:0]  score_q, score_d;
    logic        jump_req_q, jump_req_d;
    logic        vs_q;
    logic        coll_q, coll_d;
    logic        cs_q, cs_d;
    logic        wr_q, wr_d;
    logic [8:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        busy_q, busy_d;
    logic        go_q, go_d;

    logic        tick;
    logic        restart_go;
    logic        rising;
    logic [7:0]  rise_cnt;
    phase_t      nxt_phase;
    logic [7:0]  nxt_cnt;
    logic [7:0]  nxt_y;
    logic [7:0]  nxt_cac;
    logic [3:0]  nxt_score;
    logic        nxt_coll;

    assign tick = vs_q & ~vga_vs;

`ifdef COLLISION_EN
    logic [8:0] dx;

    assign restart_go = restart;
    assign dx = (nxt_cac >= DINO_X8) ? ({1'b0, nxt_cac} - {1'b0, DINO_X8})
                                     : ({1'b0, DINO_X8} - {1'b0, nxt_cac});
    assign nxt_coll = (dx < 9'd32) && (({1'b0, nxt_y} + 9'd32) > {1'b0, GROUND8});
`else
    logic unused_restart;

    assign unused_restart = restart;
    assign restart_go     = 1'b0;
    assign nxt_coll       = 1'b0;
`endif

    // Next-frame physics; only committed in UPDATE. A pending jump from GROUND
    // counts as the first rising frame, so takeoff already moves the dino.
    always_comb begin
        nxt_phase = phase_q;
        nxt_cnt   = cnt_q;
        nxt_y     = dino_y_q;
        rising    = (phase_q == PH_RISE) || ((phase_q == PH_GROUND) && jump_req_q);
        rise_cnt  = (phase_q == PH_RISE) ? cnt_q : 8'd0;

        if (rising) begin
            nxt_y = dino_y_q - STEP8;
            if (rise_cnt == LAST_CNT) begin
                nxt_phase = PH_FALL;
                nxt_cnt   = 8'd0;
            end else begin
                nxt_phase = PH_RISE;
                nxt_cnt   = rise_cnt + 8'd1;
            end
        end else if (phase_q == PH_FALL) begin
            if (cnt_q == LAST_CNT) begin
                nxt_y     = GROUND8;
                nxt_phase = PH_GROUND;
                nxt_cnt   = 8'd0;
            end else begin
                nxt_y   = dino_y_q + STEP8;
                nxt_cnt = cnt_q + 8'd1;
            end
        end

        nxt_score = score_q;
        if (cac_x_q < SCROLL8) begin
            nxt_cac   = CAC_START;
            nxt_score = (score_q == 4'd9) ? 4'd0 : score_q + 4'd1;
        end else begin
            nxt_cac = cac_x_q - SCROLL8;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        dino_y_d   = dino_y_q;
        cac_x_d    = cac_x_q;
        score_d    = score_q;
        coll_d     = coll_q;
        cs_d       = cs_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        busy_d     = busy_q;
        go_d       = go_q;
        jump_req_d = jump_req_q | (jump_btn & (phase_q == PH_GROUND));

        unique case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d = S_UPDATE;
                    busy_d  = 1'b1;
                end
            end
            S_UPDATE: begin
                phase_d  = nxt_phase;
                cnt_d    = nxt_cnt;
                dino_y_d = nxt_y;
                cac_x_d  = nxt_cac;
                score_d  = nxt_score;
                coll_d   = nxt_coll;
                if ((phase_q == PH_GROUND) && jump_req_q) begin
                    jump_req_d = 1'b0;
                end
                state_d = S_WR0;
                cs_d    = 1'b1;
                wr_d    = 1'b1;
                addr_d  = 9'd0;
                wdata_d = {24'd0, DINO_X8};
            end
            S_WR0: begin
                state_d = S_WR1;
                addr_d  = 9'd1;
                wdata_d = {24'd0, dino_y_q};
            end
            S_WR1: begin
                state_d = S_WR2;
                addr_d  = 9'd6;
                wdata_d = {24'd0, cac_x_q};
            end
            S_WR2: begin
                state_d = S_WR3;
                addr_d  = 9'd7;
                wdata_d = {24'd0, GROUND8};
            end
            S_WR3: begin
                state_d = S_WR4;
                addr_d  = 9'd10;
                wdata_d = {28'd0, score_q};
            end
            S_WR4: begin
                cs_d    = 1'b0;
                wr_d    = 1'b0;
                addr_d  = 9'd0;
                wdata_d = 32'd0;
                busy_d  = 1'b0;
                if (coll_q) begin
                    state_d = S_GAME_OVER;
                    go_d    = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAME_OVER: begin
                if (restart_go) begin
                    state_d    = S_IDLE;
                    go_d       = 1'b0;
                    coll_d     = 1'b0;
                    phase_d    = PH_GROUND;
                    cnt_d      = 8'd0;
                    dino_y_d   = GROUND8;
                    cac_x_d    = CAC_START;
                    score_d    = 4'd0;
                    jump_req_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            phase_q    <= PH_GROUND;
            cnt_q      <= 8'd0;
            dino_y_q   <= GROUND8;
            cac_x_q    <= CAC_START;
            score_q    <= 4'd0;
            jump_req_q <= 1'b0;
            vs_q       <= 1'b1;
            coll_q     <= 1'b0;
            cs_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= 9'd0;
            wdata_q    <= 32'd0;
            busy_q     <= 1'b0;
            go_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            dino_y_q   <= dino_y_d;
            cac_x_q    <= cac_x_d;
            score_q    <= score_d;
            jump_req_q <= jump_req_d;
            vs_q       <= vga_vs;
            coll_q     <= coll_d;
            cs_q       <= cs_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            go_q       <= go_d;
        end
    end

    assign bus.chipselect = cs_q;
    assign bus.write      = wr_q;
    assign bus.address    = addr_q;
    assign bus.writedata  = wdata_q;
    assign busy           = busy_q;
    assign game_over      = go_q;
    assign score          = score_q;

endmodule

// File: tb/tb_dino_frame_writer.sv
// Bench for dino_frame_writer: directed frame scenarios plus a long randomised run, checked cycle by cycle
// against a frame-level game model (takeoff frame index, cactus arithmetic, burst slot counter).
`timescale 1ns/1ps
module tb_dino_frame_writer;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       vga_vs   = 1'b1;
    logic       jump_btn = 1'b0;
    logic       restart  = 1'b0;
    logic       busy;
    logic       game_over;
    logic [3:0] score;

    dino_frame_writer_if bus();

    dino_frame_writer dut (
        .clk       (clk),
        .reset     (reset),
        .vga_vs    (vga_vs),
        .jump_btn  (jump_btn),
        .restart   (restart),
        .bus       (bus),
        .busy      (busy),
        .game_over (game_over),
        .score     (score)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: m_k = 0 idle, 1 update cycle, 2..6 write slot k-2. m_jf = frames since takeoff (0 = on ground).
    int m_k, m_jf, m_y, m_cac, m_score;
    bit m_vs, m_req, m_go, m_coll;

    int wr_addr_log[$];
    int wr_data_log[$];
    int cyc_n       = 0;
    int first_wr    = -1;
    int busy_cycles = 0;
    int wraps       = 0;
    int last_sc     = 0;

    function automatic bit collide(input int cac, input int y);
`ifdef COLLISION_EN
        int dx;
        dx = (cac > 100) ? cac - 100 : 100 - cac;
        return (dx < 32) && (y + 32 > 100);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_vs = 1; m_k = 0; m_jf = 0; m_y = 100; m_cac = 250; m_score = 0;
            m_req = 0; m_go = 0; m_coll = 0;
        end else begin
            bit tick_now, ground_old, req_next;
            tick_now   = m_vs && !vga_vs;
            ground_old = (m_jf == 0);
            req_next   = m_req || (jump_btn && ground_old);
            m_vs       = vga_vs;
            if (m_go) begin
                if (restart) begin
                    m_go = 0; m_coll = 0; m_jf = 0; m_y = 100; m_cac = 250; m_score = 0;
                    req_next = 0;
                end
            end else if (m_k == 0) begin
                if (tick_now) m_k = 1;
            end else if (m_k == 1) begin
                if (ground_old && m_req) begin
                    m_jf = 1;
                    req_next = 0;
                end else if (m_jf != 0) begin
                    m_jf++;
                end
                m_y = (m_jf <= 12) ? 100 - 4 * m_jf : 100 - 4 * (24 - m_jf);
                if (m_jf == 24) m_jf = 0;
                if (m_cac < 2) begin
                    m_cac   = 250;
                    m_score = (m_score + 1) % 10;
                end else begin
                    m_cac -= 2;
                end
                m_coll = collide(m_cac, m_y);
                m_k = 2;
            end else if (m_k < 6) begin
                m_k++;
            end else begin
                m_k  = 0;
                m_go = m_coll;
            end
            m_req = req_next;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            bit e_cs, e_busy;
            int e_addr, e_data;
            cyc_n++;
            e_cs   = (m_k >= 2);
            e_busy = (m_k != 0);
            e_addr = 0;
            e_data = 0;
            case (m_k)
                2: begin e_addr = 0;  e_data = 100;     end
                3: begin e_addr = 1;  e_data = m_y;     end
                4: begin e_addr = 6;  e_data = m_cac;   end
                5: begin e_addr = 7;  e_data = 100;     end
                6: begin e_addr = 10; e_data = m_score; end
                default: ;
            endcase
            checks++;
            if (bus.chipselect !== e_cs || bus.write !== e_cs || busy !== e_busy ||
                game_over !== m_go || score !== m_score[3:0] ||
                (e_cs && (bus.address !== e_addr[8:0] || bus.writedata !== e_data))) begin
                errors++;
                $display("FAIL cycle %0d: cs=%b wr=%b addr=%0d data=%0d busy=%b go=%b score=%0d; expected cs=%b addr=%0d data=%0d busy=%b go=%b score=%0d",
                         cyc_n, bus.chipselect, bus.write, bus.address, bus.writedata, busy, game_over, score,
                         e_cs, e_addr, e_data, e_busy, m_go, m_score);
            end
            if (bus.chipselect === 1'b1 && bus.write === 1'b1) begin
                wr_addr_log.push_back(int'(bus.address));
                wr_data_log.push_back(int'(bus.writedata));
                if (first_wr < 0) first_wr = cyc_n;
            end
            if (busy === 1'b1) busy_cycles++;
            if (last_sc == 9 && score == 4'd0) wraps++;
            last_sc = int'(score);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input int lo, input int hi);
        vga_vs = 1'b0;
        cyc(lo);
        vga_vs = 1'b1;
        cyc(hi);
    endtask

    task automatic clear_log();
        wr_addr_log.delete();
        wr_data_log.delete();
    endtask

    task automatic check_burst(input string tag, input int y, input int cac, input int sc);
        int ea[5];
        int ed[5];
        ea = '{0, 1, 6, 7, 10};
        ed = '{100, y, cac, 100, sc};
        check({tag, "_len"}, wr_addr_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("%s_addr%0d", tag, i), (i < wr_addr_log.size()) ? wr_addr_log[i] : -1, ea[i]);
            check($sformatf("%s_data%0d", tag, i), (i < wr_data_log.size()) ? wr_data_log[i] : -1, ed[i]);
        end
    endtask

    task automatic rcyc(input int n);
        for (int i = 0; i < n; i++) begin
            jump_btn = ($urandom_range(0, 7) == 0);
            restart  = ($urandom_range(0, 31) == 0);
            cyc(1);
        end
        jump_btn = 1'b0;
        restart  = 1'b0;
    endtask

    initial begin
        int t0;
        reset = 1'b1;
        cyc(3);
        check("rst_cs", int'(bus.chipselect), 0);
        check("rst_wr", int'(bus.write), 0);
        check("rst_addr", int'(bus.address), 0);
        check("rst_data", int'(bus.writedata), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_go", int'(game_over), 0);
        check("rst_score", int'(score), 0);
        reset = 1'b0;
        cyc(2);

        // First frame after reset
        clear_log();
        busy_cycles = 0;
        t0 = cyc_n;
        frame(2, 10);
        check_burst("first", 100, 248, 0);
        check("first_latency", first_wr - t0, 3);
        check("first_busy_len", busy_cycles, 6);

        // Jump: 12 rising frames, 12 falling, then ground; a mid-air press is ignored
        jump_btn = 1'b1; cyc(1); jump_btn = 1'b0; cyc(2);
        clear_log();
        for (int f = 0; f < 26; f++) begin
            frame(2, 10);
            if (f == 5) begin
                jump_btn = 1'b1; cyc(2); jump_btn = 1'b0;
            end
        end
        check("jump_bursts", wr_addr_log.size(), 130);
        for (int f = 0; f < 26; f++) begin
            int ey;
            ey = (f < 12) ? 96 - 4 * f : (f < 24) ? 56 + 4 * (f - 12) : 100;
            check($sformatf("jump_y%0d", f), (5 * f + 1 < wr_data_log.size()) ? wr_data_log[5 * f + 1] : -1, ey);
        end

        // Ticks during a burst are dropped; holding vga_vs low yields one tick
        clear_log();
        frame(1, 1); frame(1, 1); frame(2, 12);
        check("overlap_writes", wr_addr_log.size(), 5);
        clear_log();
        frame(20, 10);
        check("hold_low_writes", wr_addr_log.size(), 5);

        // Reset during WR2 abandons the burst immediately
        vga_vs = 1'b0;
        cyc(4);
        check("wr2_cs", int'(bus.chipselect), 1);
        check("wr2_addr", int'(bus.address), 6);
        #2 reset = 1'b1;
        #1;
        check("midrst_cs", int'(bus.chipselect), 0);
        check("midrst_wr", int'(bus.write), 0);
        check("midrst_busy", int'(busy), 0);
        cyc(2);
        vga_vs = 1'b1;
        reset  = 1'b0;
        cyc(3);
        clear_log();
        frame(2, 10);
        check_burst("post_rst", 100, 248, 0);

`ifdef COLLISION_EN
        // Grounded dino meets cactus at x=130; burst still written, then game over until restart
        begin
            int n;
            n = 0;
            while (game_over !== 1'b1 && n < 200) begin
                clear_log();
                frame(2, 10);
                n++;
            end
            check("coll_go", int'(game_over), 1);
            check("coll_cac", (wr_data_log.size() > 2) ? wr_data_log[2] : -1, 130);
            clear_log();
            frame(2, 10);
            check("go_no_writes", wr_addr_log.size(), 0);
            restart = 1'b1; cyc(1); restart = 1'b0;
            check("restart_go", int'(game_over), 0);
            cyc(2);
            clear_log();
            frame(2, 10);
            check_burst("restart", 100, 248, 0);
        end
`endif

        // Long randomised run: random frame lengths (some shorter than a burst), button and restart
        for (int f = 0; f < 1500; f++) begin
            int lo, hi;
            lo = $urandom_range(1, 3);
            hi = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 4) : $urandom_range(8, 14);
            vga_vs = 1'b0;
            rcyc(lo);
            vga_vs = 1'b1;
            rcyc(hi);
        end
`ifndef COLLISION_EN
        check("score_wrapped", (wraps >= 1) ? 1 : 0, 1);
`endif
        cyc(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dino_frame_writer.md
Name: dino_frame_writer

Overview:
- Hardware game-state engine. It is the bus initiator that drives the sprite/score register write port of the VGA sprite display block (chipselect/write/address/writedata).
- Once per video frame, on the falling edge of vertical sync, it advances dino jump physics, cactus scroll and score.
- It then bursts the updated values into the display registers.
- It replaces software position updates for the Dino Run demo.

Parameters:
DINO_X, 100, fixed dino x written to address 0
GROUND_Y, 100, dino y when on ground; also cactus y written to address 7
JUMP_STEP, 4, pixels per frame of rise/fall
JUMP_FRAMES, 12, frames of rise, then the same number of frames of fall (GROUND_Y >= JUMP_STEP*JUMP_FRAMES)
CAC_START_X, 250, cactus x after reset, restart or wrap
SCROLL_STEP, 2, cactus pixels per frame leftwards

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-high reset
vga_vs  in  1  VGA_VS from the display block, active-low sync
jump_btn  in  1  level jump request, synchronous to clk
restart  in  1  single-cycle pulse; leaves GAME_OVER
chipselect  out  1  write-port select to the display block
write  out  1  write strobe
address  out  9  register address
writedata  out  32  register data, zero-extended
busy  out  1  high from UPDATE through last write cycle
game_over  out  1  high while in GAME_OVER
score  out  4  current score digit 0..9

Behaviour:
- All state and outputs are registered. Reset is asynchronous, active-high.
- Reset values:
  - chipselect=0, write=0, address=0, writedata=0, busy=0, game_over=0, score=0.
  - Internal: dino_y=GROUND_Y, jump phase GROUND, jump counter 0, cac_x=CAC_START_X, jump_req=0, vs_q=1.
- Frame tick:
  - vs_q registers vga_vs every cycle.
  - tick = vs_q & ~vga_vs, one cycle per frame.
- jump_req:
  - Set in any cycle where jump_btn=1 and jump phase is GROUND.
  - Cleared when consumed in UPDATE.
  - Presses while airborne are ignored.
- Control FSM states: IDLE, UPDATE, WR0..WR4, GAME_OVER.
  - IDLE: if tick, go to UPDATE.
  - UPDATE (1 cycle, busy=1) computes next-frame values:
    - Jump phase:
      - GROUND with jump_req: go to RISE, counter=0.
      - RISE: dino_y -= JUMP_STEP and counter++; at counter==JUMP_FRAMES-1, go to FALL and reset counter.
      - FALL: dino_y += JUMP_STEP; after JUMP_FRAMES frames, dino_y=GROUND_Y exactly and phase GROUND.
    - Cactus: if cac_x < SCROLL_STEP, cac_x=CAC_START_X and score=(score==9)?0:score+1; else cac_x -= SCROLL_STEP. All 8-bit, no underflow.
  - WR0..WR4: one write per cycle, chipselect=write=1, in order:
    - addr 0 = DINO_X
    - addr 1 = dino_y
    - addr 6 = cac_x
    - addr 7 = GROUND_Y
    - addr 10 = score (bits [3:0])
    - writedata upper bits are zero.
  - After WR4: chipselect=write=0, busy=0. Go to GAME_OVER if a collision was flagged in UPDATE (see Optional Feature), else IDLE.
- Latency: the first write appears 2 cycles after the tick cycle; the burst lasts 5 consecutive cycles. The write port has no waitrequest.
- tick during UPDATE/WR*: ignored; that frame is skipped with no queuing.
- GAME_OVER:
  - game_over=1; ticks are ignored and no writes are issued.
  - A restart pulse reinitialises dino_y, phase, cac_x, score=0 and jump_req=0, then goes to IDLE. The next tick produces a normal burst carrying the reset values.
  - restart outside GAME_OVER is ignored.
- Reset mid-burst: outputs drop to 0 immediately; the burst is abandoned.

Optional Feature:
COLLISION_EN
- Defined: UPDATE flags a collision when |new cac_x − DINO_X| < 32 and new dino_y + 32 > GROUND_Y, using 9-bit unsigned compare. The full burst carrying the colliding positions is still written before entering GAME_OVER.
- Undefined: no collision logic. GAME_OVER is unreachable, game_over is tied 0, and restart is ignored.

Test Plan:
- Reset, then a vga_vs 1→0 edge → exactly one burst 2 cycles later: (0,100),(1,100),(6,248),(7,100),(10,0); busy high 6 cycles.
- jump_btn pulse, then 12 ticks → dino_y at addr 1 reads 96,92,…,52. The next 12 ticks read 56…100, then it stays 100. A second press mid-air has no effect.
- Start with CAC_START_X=3, SCROLL_STEP=2 → cac_x writes 1, then 3 with score 1. After 10 wraps, score wraps to 0.
- Hold vga_vs low and toggle during a burst → no second burst, no extra write strobes.
- COLLISION_EN with dino grounded: when cac_x reaches 130 (|130−100|<32) → burst written, game_over=1, later ticks produce no writes. restart → next tick writes cac_x=248, score=0.
- Assert reset during WR2 → chipselect/write=0 in the same cycle. After release, the first tick gives a full burst with reset values.
